// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package alu_muldiv_pkg;

  // Default operand width (HI and LO are each this wide).
  localparam int DEF_WIDTH = 32;

  // Op select encodings.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Controller states: FIX is the single result/done cycle.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/div_restore_step.sv
// One iteration of unsigned restoring division: shift {R,Q} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_restore_step
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Shift, trial subtract and restore; one extra guard bit carries the sign.
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    diff_s    = shifted_s - {2'b00, div_i};
    if (diff_s[WIDTH+1] == 1'b0) begin
      rem_o = diff_s[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit with a
// start/busy/done handshake. Results are registered and held in hi/lo until
// the next completion or reset.
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_START = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  // Architectural state. acc_q doubles as the Booth accumulator and the
  // division remainder; q_q as the Booth multiplier and the quotient.
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Combinational helpers.
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH:0]   booth_acc_s;
  logic [WIDTH-1:0] booth_q_s;
  logic [WIDTH:0]   div_rem_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

  // Operand magnitudes for the division path (|-2^(W-1)| fits as unsigned).
  always_comb begin
    if (a[WIDTH-1]) begin
      a_mag_s = ZERO_W - a;
    end else begin
      a_mag_s = a;
    end
    if (b[WIDTH-1]) begin
      b_mag_s = ZERO_W - b;
    end else begin
      b_mag_s = b;
    end
  end

  // Booth step: add/subtract multiplicand from {q0,q_-1}, then arithmetic shift right.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum_s = acc_q + mcand_q;
      2'b10:   booth_sum_s = acc_q - mcand_q;
      default: booth_sum_s = acc_q;
    endcase
    booth_acc_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
    booth_q_s   = {booth_sum_s[0], q_q[WIDTH-1:1]};
  end

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i (acc_q),
    .quo_i (q_q),
    .div_i (mcand_q[WIDTH-1:0]),
    .rem_o (div_rem_s),
    .quo_o (div_quo_s)
  );

  // Sign correction of the final division step (truncating semantics).
  always_comb begin
    if (sign_a_q ^ sign_b_q) begin
      quo_fix_s = ZERO_W - div_quo_s;
    end else begin
      quo_fix_s = div_quo_s;
    end
    if (sign_a_q) begin
      rem_fix_s = ZERO_W - div_rem_s[WIDTH-1:0];
    end else begin
      rem_fix_s = div_rem_s[WIDTH-1:0];
    end
  end

  // Next-state and datapath control; results are written on the edge entering FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    mcand_d  = mcand_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, FIX: begin
        if (start) begin
          cnt_d    = CNT_START;
          acc_d    = {(WIDTH+1){1'b0}};
          qm1_d    = 1'b0;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          dbz_d    = 1'b0;
          case (op)
            OP_MUL: begin
              state_d = MUL;
              q_d     = a;
              mcand_d = {b[WIDTH-1], b};
              busy_d  = 1'b1;
            end
            OP_DIV: begin
              if (b == ZERO_W) begin
                state_d = FIX;
                cnt_d   = {CW{1'b0}};
                q_d     = a;
                mcand_d = {(WIDTH+1){1'b0}};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                hi_d    = a;
                lo_d    = ONES_W;
                dbz_d   = 1'b1;
              end else begin
                state_d = DIV;
                q_d     = a_mag_s;
                mcand_d = {1'b0, b_mag_s};
                busy_d  = 1'b1;
              end
            end
            default: begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          endcase
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      MUL: begin
        acc_d = booth_acc_s;
        q_d   = booth_q_s;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = booth_acc_s[WIDTH-1:0];
          lo_d    = booth_q_s;
        end else begin
          state_d = MUL;
        end
      end

      DIV: begin
        acc_d = div_rem_s;
        q_d   = div_quo_s;
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = rem_fix_s;
          lo_d    = quo_fix_s;
        end else begin
          state_d = DIV;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(WIDTH+1){1'b0}};
      q_q      <= ZERO_W;
      qm1_q    <= 1'b0;
      mcand_q  <= {(WIDTH+1){1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= ZERO_W;
      lo_q     <= ZERO_W;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      mcand_q  <= mcand_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed vector table, hand-written
// handshake/reset sequences, and randomized ops against a 64-bit arithmetic model.
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
  task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    longint sx, sy, p, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ed = 1'b0;
    if (o == 1'b0) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 32'h0) begin
      eh = x;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      el = qq[31:0];
      eh = rr[31:0];
    end
  endtask

  // Present an op in the current cycle; returns #1 after the accepting edge (cycle 1).
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom_range(0, 1));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait for done starting at cycle first_cyc; bounded to 100 cycles.
  task automatic wait_done(input int first_cyc, output int lat, output int busy_cnt,
                           output logic ok);
    lat      = first_cyc;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] eh,
                               input logic [W-1:0] el, input logic ed);
    int   lat, bc, exp_lat;
    logic ok;
    exp_lat = ed ? 1 : W + 1;
    issue(o, x, y);
    check({tag, "_dbz_c1"}, 64'(div_by_zero), 64'(ed));
    wait_done(1, lat, bc, ok);
    check({tag, "_done_seen"}, 64'(ok), 64'(1'b1));
    if (ok) begin
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
      check({tag, "_busy_at_done"}, 64'(busy), 64'(1'b0));
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, bc, npulse;
    logic         ok;
    logic         ro;
    logic [W-1:0] rx, ry, eh, el;
    logic         ed;

    vecs[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFEF, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFEF, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[8] = '{1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(1'b0));
    check("reset_done", 64'(done), 64'(1'b0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(1'b0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'(1'b0));

    // Directed table (each op issued in the previous op's done cycle).
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
    end

    // start while busy is ignored; then start in the done cycle.
    @(posedge clk);
    #1;
    issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = 1'b1;
    a     = 32'h0000_0064;
    b     = 32'h0000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat, bc, ok);
    check("ignore_done_seen", 64'(ok), 64'(1'b1));
    check("ignore_latency", 64'(lat), 64'(W + 1));
    check("ignore_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("ignore_lo", 64'(lo), 64'(32'hFFFF_FFEB));
    check("ignore_dbz", 64'(div_by_zero), 64'(1'b0));
    issue(1'b0, 32'h0001_2345, 32'h0000_0100);
    check("b2b_busy_c1", 64'(busy), 64'(1'b1));
    wait_done(1, lat, bc, ok);
    check("b2b_latency", 64'(lat), 64'(W + 1));
    check("b2b_lo", 64'(lo), 64'(32'h0123_4500));
    check("b2b_hi", 64'(hi), 64'(0));

    // Reset in cycle 10 of a multiply aborts it.
    issue(1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_done", 64'(done), 64'(1'b0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) npulse++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 64'(npulse), 64'(0));
    run_and_check("after_abort", 1'b0, 32'hFFFF_FFF6, 32'h0000_0003,
                  32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0);

    // Reset has priority over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    a     = 32'h0000_0003;
    b     = 32'h0000_0003;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("reset_vs_start_busy", 64'(busy), 64'(1'b0));
    @(posedge clk);
    #1;
    check("reset_vs_start_idle", 64'(busy), 64'(1'b0));

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        3: ry = 32'($urandom_range(1, 15));
        4: ry = 32'h8000_0000;
        default: ;
      endcase
      model(ro, rx, ry, eh, el, ed);
      run_and_check($sformatf("rand%0d", i), ro, rx, ry, eh, el, ed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
